// File: rtl/hazard_ctrl.sv
// Hazard unit for a five-stage pipeline: ALU forwarding, load-use and branch
// hazards, plus a RUN/MEMWAIT/TIMEOUT handshake with a slow data memory.
module hazard_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  rs1D,
   input  logic [4:0]  rs2D,
   input  logic [4:0]  rs1E,
   input  logic [4:0]  rs2E,
   input  logic [4:0]  rdE,
   input  logic [1:0]  ResultSrcE,
   input  logic        PCSrcE,
   input  logic [4:0]  rdM,
   input  logic        RegWriteM,
   input  logic [4:0]  rdW,
   input  logic        RegWriteW,
   input  logic        mem_access_M,
   input  logic        mem_ready,
   output logic        StallF,
   output logic        StallD,
   output logic        StallE,
   output logic        StallM,
   output logic        FlushD,
   output logic        FlushE,
   output logic        FlushW,
   output logic [1:0]  ForwardAE,
   output logic [1:0]  ForwardBE,
   output logic        mem_req,
   output logic [1:0]  state,
   output logic [15:0] stall_cnt,
   output logic        mem_timeout
);

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      MEMWAIT = 2'b01,
      TIMEOUT = 2'b10
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] wait_cnt;
   logic       mem_stall;
   logic       lw_stall;

   // Memory stage has priority over Writeback because it holds the newer value.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rs,
      input logic [4:0] rd_m,
      input logic       we_m,
      input logic [4:0] rd_w,
      input logic       we_w
   );
      if (we_m && (rd_m != 5'd0) && (rd_m == rs))
         return 2'b10;
      else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   always_comb begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      if (!rst) begin
         ForwardAE = fwd_sel(rs1E, rdM, RegWriteM, rdW, RegWriteW);
         ForwardBE = fwd_sel(rs2E, rdM, RegWriteM, rdW, RegWriteW);
      end
   end

   assign lw_stall = (ResultSrcE == 2'b01) && (rdE != 5'd0) &&
                     ((rdE == rs1D) || (rdE == rs2D));

   // NOTE: every signal assigned here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      mem_stall = 1'b0;
      mem_req   = 1'b0;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushW    = 1'b0;

      case (state_q)
         RUN: begin
            mem_stall = mem_access_M && !mem_ready;
            mem_req   = mem_access_M;
            if (mem_stall)
               state_d = MEMWAIT;
         end
         MEMWAIT: begin
            mem_stall = mem_access_M && !mem_ready;
            mem_req   = 1'b1;
            if (mem_ready)
               state_d = RUN;
            else if (wait_cnt == 8'hFF)
               state_d = TIMEOUT;
         end
         TIMEOUT: begin
            mem_stall = 1'b1;
         end
         default: begin
            state_d = RUN;
         end
      endcase

      // Outputs are forced quiet while reset is held, even though the
      // registered state is already RUN.
      if (rst) begin
         mem_req = 1'b0;
      end else if (mem_stall) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else if (PCSrcE) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
      end else if (lw_stall) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         wait_cnt    <= 8'd0;
         stall_cnt   <= 16'd0;
         mem_timeout <= 1'b0;
      end else begin
         state_q <= state_d;

         if ((state_q == RUN) && (state_d == MEMWAIT))
            wait_cnt <= 8'd0;
         else if (state_q == MEMWAIT)
            wait_cnt <= wait_cnt + 8'd1;

         if (state_d == TIMEOUT)
            mem_timeout <= 1'b1;

         if (StallF && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch priority,
// memory wait, timeout and asynchronous reset behaviour.
module tb_hazard_ctrl;

   logic        clk;
   logic        rst;
   logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
   logic [1:0]  ResultSrcE;
   logic        PCSrcE, RegWriteM, RegWriteW, mem_access_M, mem_ready;
   logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
   logic [1:0]  ForwardAE, ForwardBE;
   logic        mem_req;
   logic [1:0]  state;
   logic [15:0] stall_cnt;
   logic        mem_timeout;

   logic [6:0]  ctl;
   int          n_checks;
   int          n_errors;
   logic [15:0] exp_cnt;

   // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
   localparam logic [6:0] CTL_NONE   = 7'b0000000;
   localparam logic [6:0] CTL_MEM    = 7'b1111001;
   localparam logic [6:0] CTL_BRANCH = 7'b0000110;
   localparam logic [6:0] CTL_LW     = 7'b1100010;

   assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

   hazard_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .rs1D         (rs1D),
      .rs2D         (rs2D),
      .rs1E         (rs1E),
      .rs2E         (rs2E),
      .rdE          (rdE),
      .ResultSrcE   (ResultSrcE),
      .PCSrcE       (PCSrcE),
      .rdM          (rdM),
      .RegWriteM    (RegWriteM),
      .rdW          (rdW),
      .RegWriteW    (RegWriteW),
      .mem_access_M (mem_access_M),
      .mem_ready    (mem_ready),
      .StallF       (StallF),
      .StallD       (StallD),
      .StallE       (StallE),
      .StallM       (StallM),
      .FlushD       (FlushD),
      .FlushE       (FlushE),
      .FlushW       (FlushW),
      .ForwardAE    (ForwardAE),
      .ForwardBE    (ForwardBE),
      .mem_req      (mem_req),
      .state        (state),
      .stall_cnt    (stall_cnt),
      .mem_timeout  (mem_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      rs1D = 5'd0; rs2D = 5'd0; rs1E = 5'd0; rs2E = 5'd0;
      rdE = 5'd0; rdM = 5'd0; rdW = 5'd0;
      ResultSrcE = 2'b00; PCSrcE = 1'b0;
      RegWriteM = 1'b0; RegWriteW = 1'b0;
      mem_access_M = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_idle();
      mem_access_M = 1'b1; ResultSrcE = 2'b01; rdE = 5'd7; rs1D = 5'd7;
      PCSrcE = 1'b1; rs1E = 5'd5; rdM = 5'd5; RegWriteM = 1'b1;
      rs2E = 5'd6; rdW = 5'd6; RegWriteW = 1'b1;
      repeat (2) step();
      n_checks++; if (ctl !== CTL_NONE) begin n_errors++; $display("FAIL reset_ctl: got %b exp %b", ctl, CTL_NONE); end
      n_checks++; if (ForwardAE !== 2'b00) begin n_errors++; $display("FAIL reset_fwd_a: got %b exp 00", ForwardAE); end
      n_checks++; if (ForwardBE !== 2'b00) begin n_errors++; $display("FAIL reset_fwd_b: got %b exp 00", ForwardBE); end
      n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL reset_mem_req: got %b exp 0", mem_req); end
      n_checks++; if (state !== 2'b00) begin n_errors++; $display("FAIL reset_state: got %b exp 00", state); end
      n_checks++; if (stall_cnt !== 16'd0) begin n_errors++; $display("FAIL reset_stall_cnt: got %0d exp 0", stall_cnt); end
      n_checks++; if (mem_timeout !== 1'b0) begin n_errors++; $display("FAIL reset_timeout: got %b exp 0", mem_timeout); end
      set_idle();
      rst = 1'b0;
      exp_cnt = 16'd0;
      step();
      n_checks++; if (state !== 2'b00) begin n_errors++; $display("FAIL post_reset_state: got %b exp 00", state); end
      n_checks++; if (stall_cnt !== exp_cnt) begin n_errors++; $display("FAIL post_reset_cnt: got %0d exp %0d", stall_cnt, exp_cnt); end
   endtask

   task automatic test_forwarding();
      set_idle();
      rs1E = 5'd5; rs2E = 5'd5; rdM = 5'd5; RegWriteM = 1'b1; rdW = 5'd5; RegWriteW = 1'b1;
      #1;
      n_checks++; if (ForwardAE !== 2'b10) begin n_errors++; $display("FAIL fwd_a_mem: got %b exp 10", ForwardAE); end
      n_checks++; if (ForwardBE !== 2'b10) begin n_errors++; $display("FAIL fwd_b_mem_wins: got %b exp 10", ForwardBE); end
      RegWriteM = 1'b0;
      #1;
      n_checks++; if (ForwardAE !== 2'b01) begin n_errors++; $display("FAIL fwd_a_wb: got %b exp 01", ForwardAE); end
      n_checks++; if (ForwardBE !== 2'b01) begin n_errors++; $display("FAIL fwd_b_wb: got %b exp 01", ForwardBE); end
      rdW = 5'd0;
      #1;
      n_checks++; if (ForwardAE !== 2'b00) begin n_errors++; $display("FAIL fwd_a_none: got %b exp 00", ForwardAE); end
      rs1E = 5'd3; rs2E = 5'd9; rdM = 5'd3; RegWriteM = 1'b1; rdW = 5'd9; RegWriteW = 1'b1;
      #1;
      n_checks++; if (ForwardAE !== 2'b10) begin n_errors++; $display("FAIL fwd_a_split: got %b exp 10", ForwardAE); end
      n_checks++; if (ForwardBE !== 2'b01) begin n_errors++; $display("FAIL fwd_b_split: got %b exp 01", ForwardBE); end
      rs1E = 5'd0; rs2E = 5'd0; rdM = 5'd0; rdW = 5'd0;
      #1;
      n_checks++; if ({ForwardAE, ForwardBE} !== 4'b0000) begin n_errors++; $display("FAIL fwd_x0: got %b exp 0000", {ForwardAE, ForwardBE}); end
      n_checks++; if (ctl !== CTL_NONE) begin n_errors++; $display("FAIL fwd_ctl: got %b exp %b", ctl, CTL_NONE); end
      set_idle();
      step();
   endtask

   task automatic test_load_use();
      set_idle();
      ResultSrcE = 2'b01; rdE = 5'd7; rs2D = 5'd7; rs1D = 5'd3;
      #1;
      n_checks++; if (ctl !== CTL_LW) begin n_errors++; $display("FAIL lw_rs2_ctl: got %b exp %b", ctl, CTL_LW); end
      step(); exp_cnt++;
      set_idle();
      #1;
      n_checks++; if (stall_cnt !== exp_cnt) begin n_errors++; $display("FAIL lw_cnt: got %0d exp %0d", stall_cnt, exp_cnt); end
      n_checks++; if (ctl !== CTL_NONE) begin n_errors++; $display("FAIL lw_cleared: got %b exp %b", ctl, CTL_NONE); end
      ResultSrcE = 2'b01; rdE = 5'd12; rs1D = 5'd12;
      #1;
      n_checks++; if (ctl !== CTL_LW) begin n_errors++; $display("FAIL lw_rs1_ctl: got %b exp %b", ctl, CTL_LW); end
      step(); exp_cnt++;
      rdE = 5'd0; rs1D = 5'd0; rs2D = 5'd0;
      #1;
      n_checks++; if (ctl !== CTL_NONE) begin n_errors++; $display("FAIL lw_x0: got %b exp %b", ctl, CTL_NONE); end
      ResultSrcE = 2'b00; rdE = 5'd7; rs1D = 5'd7;
      #1;
      n_checks++; if (ctl !== CTL_NONE) begin n_errors++; $display("FAIL lw_not_load: got %b exp %b", ctl, CTL_NONE); end
      step();
      n_checks++; if (stall_cnt !== exp_cnt) begin n_errors++; $display("FAIL lw_cnt2: got %0d exp %0d", stall_cnt, exp_cnt); end
      set_idle();
   endtask

   task automatic test_branch();
      set_idle();
      PCSrcE = 1'b1; ResultSrcE = 2'b01; rdE = 5'd7; rs2D = 5'd7;
      #1;
      n_checks++; if (ctl !== CTL_BRANCH) begin n_errors++; $display("FAIL branch_over_lw: got %b exp %b", ctl, CTL_BRANCH); end
      step();
      set_idle();
      #1;
      n_checks++; if (stall_cnt !== exp_cnt) begin n_errors++; $display("FAIL branch_cnt: got %0d exp %0d", stall_cnt, exp_cnt); end
   endtask

   task automatic test_single_cycle();
      set_idle();
      mem_access_M = 1'b1; mem_ready = 1'b1;
      #1;
      n_checks++; if (ctl !== CTL_NONE) begin n_errors++; $display("FAIL single_ctl: got %b exp %b", ctl, CTL_NONE); end
      n_checks++; if (mem_req !== 1'b1) begin n_errors++; $display("FAIL single_req: got %b exp 1", mem_req); end
      step();
      n_checks++; if (state !== 2'b00) begin n_errors++; $display("FAIL single_state: got %b exp 00", state); end
      set_idle();
      #1;
      n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL idle_req: got %b exp 0", mem_req); end
   endtask

   task automatic test_mem_wait();
      set_idle();
      mem_access_M = 1'b1; mem_ready = 1'b0;
      PCSrcE = 1'b1; ResultSrcE = 2'b01; rdE = 5'd7; rs2D = 5'd7;
      #1;
      n_checks++; if (ctl !== CTL_MEM) begin n_errors++; $display("FAIL wait1_ctl: got %b exp %b", ctl, CTL_MEM); end
      n_checks++; if ({state, mem_req} !== 3'b001) begin n_errors++; $display("FAIL wait1_state_req: got %b exp 001", {state, mem_req}); end
      step(); exp_cnt++;
      PCSrcE = 1'b0; ResultSrcE = 2'b00;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_checks++; if (ctl !== CTL_MEM) begin n_errors++; $display("FAIL wait%0d_ctl: got %b exp %b", i + 2, ctl, CTL_MEM); end
         n_checks++; if ({state, mem_req} !== 3'b011) begin n_errors++; $display("FAIL wait%0d_state_req: got %b exp 011", i + 2, {state, mem_req}); end
         step(); exp_cnt++;
      end
      mem_ready = 1'b1;
      #1;
      n_checks++; if (ctl !== CTL_NONE) begin n_errors++; $display("FAIL ready_ctl: got %b exp %b", ctl, CTL_NONE); end
      n_checks++; if ({state, mem_req} !== 3'b011) begin n_errors++; $display("FAIL ready_state_req: got %b exp 011", {state, mem_req}); end
      step();
      set_idle();
      #1;
      n_checks++; if (state !== 2'b00) begin n_errors++; $display("FAIL wait_done_state: got %b exp 00", state); end
      n_checks++; if (stall_cnt !== exp_cnt) begin n_errors++; $display("FAIL wait_cnt: got %0d exp %0d", stall_cnt, exp_cnt); end
   endtask

   task automatic test_reset_in_memwait();
      set_idle();
      mem_access_M = 1'b1; mem_ready = 1'b0;
      step(); exp_cnt++;
      n_checks++; if (state !== 2'b01) begin n_errors++; $display("FAIL rstw_enter: got %b exp 01", state); end
      #2 rst = 1'b1;
      #1;
      n_checks++; if (state !== 2'b00) begin n_errors++; $display("FAIL rstw_async_state: got %b exp 00", state); end
      n_checks++; if ({ctl, mem_req} !== 8'd0) begin n_errors++; $display("FAIL rstw_outputs: got %b exp 0", {ctl, mem_req}); end
      n_checks++; if (stall_cnt !== 16'd0) begin n_errors++; $display("FAIL rstw_cnt: got %0d exp 0", stall_cnt); end
      #1 rst = 1'b0;
      exp_cnt = 16'd0;
      step(); exp_cnt++;
      n_checks++; if (state !== 2'b01) begin n_errors++; $display("FAIL rstw_first_edge: got %b exp 01", state); end
      n_checks++; if (stall_cnt !== exp_cnt) begin n_errors++; $display("FAIL rstw_cnt2: got %0d exp %0d", stall_cnt, exp_cnt); end
      mem_ready = 1'b1;
      step();
      n_checks++; if (state !== 2'b00) begin n_errors++; $display("FAIL rstw_back_run: got %b exp 00", state); end
      set_idle();
   endtask

   task automatic test_timeout();
      set_idle();
      mem_access_M = 1'b1; mem_ready = 1'b0;
      repeat (256) begin
         step(); exp_cnt++;
      end
      n_checks++; if (state !== 2'b01) begin n_errors++; $display("FAIL to_last_wait: got %b exp 01", state); end
      n_checks++; if (mem_timeout !== 1'b0) begin n_errors++; $display("FAIL to_early_flag: got %b exp 0", mem_timeout); end
      step(); exp_cnt++;
      n_checks++; if (state !== 2'b10) begin n_errors++; $display("FAIL to_state: got %b exp 10", state); end
      n_checks++; if (mem_timeout !== 1'b1) begin n_errors++; $display("FAIL to_flag: got %b exp 1", mem_timeout); end
      n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL to_req: got %b exp 0", mem_req); end
      n_checks++; if (stall_cnt !== exp_cnt) begin n_errors++; $display("FAIL to_cnt: got %0d exp %0d", stall_cnt, exp_cnt); end
      mem_ready = 1'b1;
      #1;
      n_checks++; if (ctl !== CTL_MEM) begin n_errors++; $display("FAIL to_stall_ready: got %b exp %b", ctl, CTL_MEM); end
      step(); exp_cnt++;
      n_checks++; if (state !== 2'b10) begin n_errors++; $display("FAIL to_held: got %b exp 10", state); end
      n_checks++; if (stall_cnt !== exp_cnt) begin n_errors++; $display("FAIL to_cnt2: got %0d exp %0d", stall_cnt, exp_cnt); end
      #2 rst = 1'b1;
      #1;
      n_checks++; if ({state, mem_timeout} !== 3'b000) begin n_errors++; $display("FAIL to_rst_state_flag: got %b exp 000", {state, mem_timeout}); end
      n_checks++; if (stall_cnt !== 16'd0) begin n_errors++; $display("FAIL to_rst_cnt: got %0d exp 0", stall_cnt); end
      #1 rst = 1'b0;
      set_idle();
      exp_cnt = 16'd0;
      step();
      n_checks++; if ({state, mem_timeout, ctl} !== 10'd0) begin n_errors++; $display("FAIL to_after_rst: got %b exp 0", {state, mem_timeout, ctl}); end
      n_checks++; if (stall_cnt !== exp_cnt) begin n_errors++; $display("FAIL to_after_cnt: got %0d exp %0d", stall_cnt, exp_cnt); end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      exp_cnt  = 16'd0;
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch();
      test_single_cycle();
      test_mem_wait();
      test_reset_in_memwait();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rs1D, rs2D  in  5  source registers in Decode
- rs1E, rs2E  in  5  source registers in Execute
- rdE  in  5  destination register in Execute
- ResultSrcE  in  2  Execute result select; 2'b01 = load
- PCSrcE  in  1  taken branch/jump resolved in Execute
- rdM  in  5  destination register in Memory
- RegWriteM  in  1  Memory stage writes rd
- rdW  in  5  destination register in Writeback
- RegWriteW  in  1  Writeback stage writes rd
- mem_access_M  in  1  load/store present in Memory
- mem_ready  in  1  data memory completes the access this cycle
- StallF, StallD, StallE, StallM  out  1  hold the respective pipeline register
- FlushD, FlushE, FlushW  out  1  load a bubble into IF/ID, ID/EX, MEM/WB
- ForwardAE, ForwardBE  out  2  00 = register file, 10 = ALU result in Memory, 01 = result in Writeback
- mem_req  out  1  data memory request
- state  out  2  FSM state: 00 RUN, 01 MEMWAIT, 10 TIMEOUT
- stall_cnt  out  16  saturating count of cycles with StallF=1
- mem_timeout  out  1  sticky memory-timeout error flag
REQ-002 SHALL use one clock; reset is asynchronous and active-high.

Function
REQ-003 ForwardAE SHALL be combinational: 10 if RegWriteM and rdM!=0 and rdM==rs1E; else 01 if RegWriteW and rdW!=0 and rdW==rs1E; else 00.
REQ-004 ForwardBE SHALL follow REQ-003 with rs2E in place of rs1E; when both Memory and Writeback match, Memory wins.
REQ-005 lwStall SHALL be ResultSrcE==01 and rdE!=0 and (rdE==rs1D or rdE==rs2D).
REQ-006 memStall SHALL be 1 when mem_access_M and not mem_ready in state RUN or MEMWAIT, and 1 unconditionally in TIMEOUT.
REQ-007 Priority SHALL be memStall > PCSrcE > lwStall.
REQ-008 On memStall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0.
REQ-009 On PCSrcE without memStall: FlushD=FlushE=1, StallF=StallD=0, even when lwStall=1.
REQ-010 On lwStall alone: StallF=StallD=1, FlushE=1, FlushD=0.
REQ-011 Stall and flush outputs not asserted by REQ-008 to REQ-010 SHALL be 0.
REQ-012 FSM transitions:
- RUN -> MEMWAIT when mem_access_M and not mem_ready.
- MEMWAIT -> RUN on mem_ready.
- MEMWAIT -> TIMEOUT when the wait counter reaches 255 without mem_ready.
- TIMEOUT is held until reset.
REQ-013 mem_req SHALL be 1 in RUN when mem_access_M=1, 1 throughout MEMWAIT, and 0 in TIMEOUT.
REQ-014 The 8-bit wait counter SHALL clear on entry to MEMWAIT and increment each cycle in MEMWAIT; the TIMEOUT check uses the registered counter value.
REQ-015 A single-cycle access (mem_access_M=1, mem_ready=1 in RUN) SHALL cause no stall and no state change.
REQ-016 mem_timeout SHALL set on entry to TIMEOUT and stay 1 until reset.
REQ-017 stall_cnt SHALL increment on every clock edge where StallF=1 and saturate at 16'hFFFF.

Reset
REQ-018 While rst=1, all outputs SHALL be 0: state=RUN, wait counter=0, stall_cnt=0, mem_timeout=0, mem_req=0, every stall/flush=0, ForwardAE=ForwardBE=00.
REQ-019 Reset asserted during MEMWAIT or TIMEOUT SHALL return the block to RUN asynchronously.
REQ-020 After rst falls, the first rising edge SHALL evaluate from RUN.

Verification
REQ-021 Forwarding: rs1E=5, rdM=5, RegWriteM=1, rdW=5, RegWriteW=1 -> ForwardAE=10; then RegWriteM=0 -> ForwardAE=01; then rdW=0 -> ForwardAE=00.
REQ-022 Load-use: ResultSrcE=01, rdE=7, rs2D=7 -> StallF=StallD=FlushE=1 for that cycle; stall_cnt +1.
REQ-023 Branch vs load-use: PCSrcE=1 with REQ-022 inputs -> FlushD=FlushE=1, StallF=0.
REQ-024 Memory wait: mem_access_M=1, mem_ready=0 for 3 cycles, then 1 -> 3 cycles with StallF..StallM=FlushW=1; state 01 then 00; mem_req=1 throughout.
REQ-025 Timeout: mem_ready held 0 -> state=10 and mem_timeout=1 after 256 MEMWAIT cycles; mem_req=0; rst pulse -> state=00, mem_timeout=0, stall_cnt=0.
